// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 opcode, memory-access code types and datapath widths
package lc3_pkg;
  localparam int MEM_W = 16;
  localparam int ADDR_W = 16;
  typedef enum logic [3:0] {
    OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR,
    OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP
  } op_t;
  typedef enum logic [1:0] {
    MS_READ = 2'd0,
    MS_IND = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE = 2'd3
  } mem_state_t;
endpackage

// File: rtl/lc3_mem_access.sv
// lc3_mem_access: LC-3 memory-access stage driving a req/ack data-memory bus
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_state,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [MEM_W-1:0]  M_Data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [MEM_W-1:0]  dmem_din,
  input  logic [MEM_W-1:0]  dmem_dout,
  input  logic              dmem_ack,
  output logic [MEM_W-1:0]  memout,
  output logic              complete_data,
  output logic              mem_err
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  localparam int CW = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
  logic [1:0] state, code, last_code;
  logic [ADDR_W-1:0] ind_ptr;
  logic ind_valid;
  logic [CW-1:0] wait_cnt;
  logic start;
  assign start = (state == IDLE) && (mem_state != MS_IDLE) && (mem_state != last_code);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code <= MS_IDLE;
      last_code <= MS_IDLE;
      ind_ptr <= '0;
      ind_valid <= 1'b0;
      wait_cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_din <= '0;
      memout <= '0;
      complete_data <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      complete_data <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_state == MS_IDLE) last_code <= MS_IDLE;
          if (start) begin
            state <= ACCESS;
            code <= mem_state;
            dmem_req <= 1'b1;
            dmem_we <= mem_state == MS_WRITE;
            dmem_addr <= (mem_state != MS_IND && ind_valid) ? ind_ptr : M_Addr;
            dmem_din <= M_Data;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state <= DONE;
            dmem_req <= 1'b0;
            complete_data <= 1'b1;
            if (code == MS_READ) memout <= dmem_dout;
            if (code == MS_IND) begin
              ind_ptr <= dmem_dout;
              ind_valid <= 1'b1;
            end
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            state <= DONE;
            dmem_req <= 1'b0;
            complete_data <= 1'b1;
            mem_err <= 1'b1;
            ind_valid <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          last_code <= code;
          if (code != MS_IND) ind_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_access.sv
// tb_lc3_mem_access: table, hand-written and randomized checks against a transaction-level model
module tb_lc3_mem_access;
  localparam int WAIT_MAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mem_state = 2'd3;
  logic [15:0] M_Addr = '0, M_Data = '0, dmem_dout = '0;
  logic dmem_ack = 1'b0;
  logic dmem_req, dmem_we, complete_data, mem_err;
  logic [15:0] dmem_addr, dmem_din, memout;
  int checks = 0, errors = 0;
  logic [15:0] m_ptr = '0, m_mem = '0;
  logic m_valid = 1'b0, m_err = 1'b0;

  lc3_mem_access #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .mem_state(mem_state), .M_Addr(M_Addr), .M_Data(M_Data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .dmem_ack(dmem_ack), .memout(memout),
    .complete_data(complete_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] c;
    logic [15:0] a, d;
    int dly;
    logic [15:0] resp, e_addr;
    logic e_we;
    logic [15:0] e_mem;
    logic e_iv;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_addr(input logic [1:0] c, input logic [15:0] a);
    return (c == 2'd1 || !m_valid) ? a : m_ptr;
  endfunction

  task automatic model_apply(input logic [1:0] c, input int dly, input logic [15:0] resp);
    if (dly > WAIT_MAX) begin
      m_err = 1'b1;
      m_valid = 1'b0;
    end else if (c == 2'd1) begin
      m_ptr = resp;
      m_valid = 1'b1;
    end else begin
      if (c == 2'd0) m_mem = resp;
      m_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] c, input logic [15:0] a, d, input int dly,
                        input logic [15:0] resp, e_addr, input logic e_we,
                        input logic [15:0] e_mem, input logic e_err);
    int n = 0, at = -1;
    int n_exp = (dly <= WAIT_MAX) ? dly : WAIT_MAX;
    @(negedge clk);
    mem_state = c;
    M_Addr = a;
    M_Data = d;
    for (int cyc = 0; cyc < WAIT_MAX + 4 && at < 0; cyc++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (complete_data) at = cyc;
      else if (dmem_req) begin
        n++;
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_we", dmem_we, e_we);
        if (e_we) check("dmem_din", dmem_din, d);
        if (n == dly) begin
          dmem_ack = 1'b1;
          dmem_dout = resp;
        end
      end
    end
    if (at < 0) begin
      errors++;
      $display("FAIL complete_wait: got no complete_data expected a pulse at %0t", $time);
    end
    check("req_cycles", 16'(n), 16'(n_exp));
    check("latency", 16'(at), 16'(n_exp));
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("single_pulse", complete_data, 1'b0);
      check("no_reissue", dmem_req, 1'b0);
    end
    check("memout", memout, e_mem);
    check("mem_err", mem_err, e_err);
    mem_state = 2'd3;
  endtask

  initial begin
    tbl[0] = '{2'd0, 16'h3010, 16'h0000, 4, 16'hBEEF, 16'h3010, 1'b0, 16'hBEEF, 1'b0};
    tbl[1] = '{2'd1, 16'h3000, 16'h0000, 2, 16'h4000, 16'h3000, 1'b0, 16'hBEEF, 1'b1};
    tbl[2] = '{2'd0, 16'h5555, 16'h0000, 1, 16'h1234, 16'h4000, 1'b0, 16'h1234, 1'b0};
    tbl[3] = '{2'd1, 16'h3000, 16'h0000, 1, 16'h4100, 16'h3000, 1'b0, 16'h1234, 1'b1};
    tbl[4] = '{2'd2, 16'h6666, 16'h00AA, 3, 16'h0000, 16'h4100, 1'b1, 16'h1234, 1'b0};
    tbl[5] = '{2'd2, 16'h2000, 16'h5A5A, 1, 16'h0000, 16'h2000, 1'b1, 16'h1234, 1'b0};
    tbl[6] = '{2'd0, 16'h2001, 16'h0000, 2, 16'h0F0F, 16'h2001, 1'b0, 16'h0F0F, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 16'h0000);
    check("rst_din", dmem_din, 16'h0000);
    check("rst_memout", memout, 16'h0000);
    check("rst_complete", complete_data, 1'b0);
    check("rst_err", mem_err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].resp,
             tbl[i].e_addr, tbl[i].e_we, tbl[i].e_mem, 1'b0);
      model_apply(tbl[i].c, tbl[i].dly, tbl[i].resp);
      check("ind_valid", dut.ind_valid, tbl[i].e_iv);
    end
    run_op(2'd0, 16'h1111, 16'h0000, 9, 16'hDEAD, 16'h1111, 1'b0, 16'h0F0F, 1'b1);
    model_apply(2'd0, 9, 16'hDEAD);
    run_op(2'd2, 16'h2222, 16'h3333, 1, 16'h0000, 16'h2222, 1'b1, 16'h0F0F, 1'b1);
    model_apply(2'd2, 1, 16'h0000);
    @(negedge clk);
    mem_state = 2'd0;
    M_Addr = 16'h7777;
    @(negedge clk);
    check("rst_mid_req_before", dmem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req", dmem_req, 1'b0);
    check("rst_mid_we", dmem_we, 1'b0);
    check("rst_mid_addr", dmem_addr, 16'h0000);
    check("rst_mid_din", dmem_din, 16'h0000);
    check("rst_mid_memout", memout, 16'h0000);
    check("rst_mid_complete", complete_data, 1'b0);
    check("rst_mid_err", mem_err, 1'b0);
    check("rst_mid_ind_valid", dut.ind_valid, 1'b0);
    rst = 1'b0;
    mem_state = 2'd3;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("rst_mid_no_complete", complete_data, 1'b0);
    end
    m_ptr = '0;
    m_mem = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      logic [15:0] a, d, resp, ea;
      int dly;
      c = 2'($urandom_range(0, 2));
      a = 16'($urandom);
      d = 16'($urandom);
      resp = 16'($urandom);
      dly = $urandom_range(1, WAIT_MAX + 2);
      ea = model_addr(c, a);
      model_apply(c, dly, resp);
      run_op(c, a, d, dly, resp, ea, c == 2'd2, m_mem, m_err);
      check("rand_ind_valid", dut.ind_valid, m_valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc3_mem_access.md
# lc3_mem_access

Memory-access stage of the LC-3 pipeline, directly downstream of the pipeline controller. It consumes the controller's `mem_state` code and performs the matching data-memory transaction over a req/ack bus:
- LD/LDR: read.
- LDI/STI: pointer read, then a read or write.
- ST/STR: write.

It returns `memout` to writeback and pulses `complete_data` back to the controller, which uses it to advance `mem_state`. It also holds the indirect pointer between the two phases of LDI/STI.

## Interface
Parameters:
- `WAIT_MAX`, default 255: maximum cycles `dmem_req` may stay high without `dmem_ack` before the access is aborted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_state` in 2: access code.
  - 0: read.
  - 1: indirect pointer read.
  - 2: write.
  - 3: idle.
- `M_Addr` in 16: effective address from execute.
- `M_Data` in 16: store data from execute.
- `dmem_req` out 1: request to data memory. Held until ack or abort.
- `dmem_we` out 1: 1 = write, 0 = read. Valid while `dmem_req` is high.
- `dmem_addr` out 16: memory address. Valid while `dmem_req` is high.
- `dmem_din` out 16: write data. Valid while `dmem_req` is high.
- `dmem_dout` in 16: read data. Valid in the ack cycle.
- `dmem_ack` in 1: one-cycle completion from memory.
- `memout` out 16: last read data. Registered.
- `complete_data` out 1: one-cycle pulse when an access finishes.
- `mem_err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Start condition (IDLE only): `mem_state != 3` and `mem_state != last_code`.
  - On start: latch the code, address and `M_Data`, then go to ACCESS.
  - `last_code` resets to 3. It is written with the completed code in DONE.
  - `last_code` is re-armed to 3 whenever IDLE sees `mem_state == 3`. This prevents re-issuing a finished access while the controller still shows the same code.
- Address select at start:
  - Code 1: `M_Addr`.
  - Code 0 or 2: `ind_ptr` if `ind_valid`, else `M_Addr`.
- ACCESS:
  - `dmem_req = 1`; `dmem_we = (code == 2)`.
  - On `dmem_ack`:
    - Read (code 0): capture `dmem_dout` into `memout`.
    - Pointer read (code 1): capture `dmem_dout` into `ind_ptr` and set `ind_valid`. `memout` is unchanged.
    - Go to DONE.
- DONE:
  - `complete_data = 1` for exactly one cycle, then go to IDLE.
  - If the code was 0 or 2, clear `ind_valid`.
- Timeout: `wait_cnt` (8+ bits) counts ACCESS cycles without ack.
  - On reaching `WAIT_MAX`: drop `dmem_req`, set `mem_err`, go to DONE.
  - `memout` and `ind_ptr` are unchanged; `ind_valid` is cleared.
- `mem_err` is cleared only by `rst`.
- Codes arriving while in ACCESS or DONE are ignored until IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_addr` = 0x0000, `dmem_din` = 0x0000.
  - `memout` = 0x0000, `complete_data` = 0, `mem_err` = 0.
  - Internal: `ind_ptr` = 0x0000, `ind_valid` = 0, `last_code` = 3, state = IDLE.
- Start seen in cycle t:
  - `dmem_req` is high from t+1.
  - If ack arrives at t+k (k ≥ 1), `complete_data` is high in t+k+1 and `memout` is valid from t+k+1.
- Minimum latency is 2 cycles from start to `complete_data`. Back-to-back restart is possible at the earliest 2 cycles after the `complete_data` cycle.
- `dmem_addr`, `dmem_we` and `dmem_din` are stable for the whole request.
- `dmem_ack` is ignored outside ACCESS.
- Ack in the same cycle the timeout is reached: the ack wins and `mem_err` is not set.
- `rst` mid-access: `dmem_req` drops at that edge, and any pending `complete_data` is suppressed.

## Structure
- Shared package `lc3_pkg`:
  - `op_t` opcode enum.
  - `mem_state_t` enum: MS_READ = 0, MS_IND = 1, MS_WRITE = 2, MS_IDLE = 3.
  - Constants: `MEM_W = 16`, `ADDR_W = 16`.
- The controller is to use the same `mem_state_t`.
- Single module, no sub-modules; the timeout counter is inline.

## Test plan
- LD: `mem_state` 3→0, `M_Addr` = 0x3010, memory returns 0xBEEF with ack 3 cycles after req.
  - Required: `dmem_addr` = 0x3010, `dmem_we` = 0, `memout` = 0xBEEF, exactly one `complete_data` pulse.
  - Holding `mem_state` at 0 afterwards issues no second request.
- LDI: code 1 with `M_Addr` = 0x3000 → mem[0x3000] = 0x4000.
  - Then code 0 → read at 0x4000 returns 0x1234.
  - Required: `memout` = 0x1234, two `complete_data` pulses, `ind_valid` low at the end.
- STI: code 1 with `M_Addr` = 0x3000 returns 0x4100, then code 2 with `M_Data` = 0x00AA.
  - Required: write request at 0x4100 with `dmem_din` = 0x00AA and `dmem_we` = 1.
- ST with ack in the first req cycle: `complete_data` exactly 2 cycles after start.
  - Then 3→0 restart with a new address succeeds.
- No ack, `WAIT_MAX` = 4: req drops after 4 cycles, `mem_err` = 1 (sticky), one `complete_data` pulse, `memout` unchanged.
- `rst` asserted in the second ACCESS cycle: req low at that edge, no `complete_data`, all outputs at reset values.
